// File: rtl/fetch_pipe_unit.sv
// Purpose : IF stage: program counter, IF/ID pipeline register, stall/flush event counters.
// Latency : 1 cycle (instr_i sampled at edge N is visible on instr_IFID_o after edge N).
// Backpr. : PCWrite_i / WritePipeReg_IFID_i hold PC / IF/ID; a redirect or flush overrides a hold.
// Ports   : clk_i, rst_i (sync, active-low); hazard controls PCWrite_i, WritePipeReg_IFID_i,
//           Flush_IFID_i, PCSrc_select_i + branch_target_i; instr_i (imem data for pc_o);
//           outputs pc_o, IF/ID {pc_plus4, instr, valid}, stall_cnt_o, flush_cnt_o (all registered).
module fetch_pipe_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             PCWrite_i,
  input  logic             WritePipeReg_IFID_i,
  input  logic             Flush_IFID_i,
  input  logic             PCSrc_select_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_IFID_o,
  output logic [31:0]      instr_IFID_o,
  output logic             valid_IFID_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [31:0] pc_inc;
  logic        flush_evt;
  logic        stall_evt;

  // Natural 32-bit addition wraps 0xFFFF_FFFC -> 0x0.
  assign pc_inc    = pc_q + 32'd4;
  // A redirect squashes the instruction fetched down the wrong path, so it counts as a flush.
  assign flush_evt = Flush_IFID_i | PCSrc_select_i;
  assign stall_evt = ~WritePipeReg_IFID_i & ~flush_evt;

  always_comb begin
    pc_d = pc_q;
    if (PCSrc_select_i) begin
      pc_d = {branch_target_i[31:2], 2'b00};
    end else if (PCWrite_i) begin
      pc_d = pc_inc;
    end
  end

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_evt) begin
      instr_d    = 32'h0;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (WritePipeReg_IFID_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_inc;
      valid_d    = 1'b1;
    end
  end

  // Saturating event counters; they stay pinned at all-ones until reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_evt && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q        <= RESET_PC;
      pc_plus4_q  <= 32'h0;
      instr_q     <= 32'h0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc_plus4_q  <= pc_plus4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_plus4_IFID_o = pc_plus4_q;
  assign instr_IFID_o    = instr_q;
  assign valid_IFID_o    = valid_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: doc/fetch_pipe_unit.md
FETCH_PIPE_UNIT -- requirements
Module: fetch_pipe_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each event counter.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port PCWrite_i  input  1  PC update enable from hazard detection.
REQ-006 The block SHALL have port WritePipeReg_IFID_i  input  1  IF/ID register load enable from hazard detection.
REQ-007 The block SHALL have port Flush_IFID_i  input  1  IF/ID flush request.
REQ-008 The block SHALL have port PCSrc_select_i  input  1  taken-branch/jump redirect.
REQ-009 The block SHALL have port branch_target_i  input  32  redirect address.
REQ-010 The block SHALL have port instr_i  input  32  instruction memory read data for pc_o, combinational.
REQ-011 The block SHALL have port pc_o  output  32  current fetch address to instruction memory.
REQ-012 The block SHALL have port pc_plus4_IFID_o  output  32  IF/ID registered PC+4.
REQ-013 The block SHALL have port instr_IFID_o  output  32  IF/ID registered instruction.
REQ-014 The block SHALL have port valid_IFID_o  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-015 The block SHALL have port stall_cnt_o  output  CNT_W  count of stall cycles.
REQ-016 The block SHALL have port flush_cnt_o  output  CNT_W  count of flush cycles.

Function
REQ-017 PC next-state SHALL follow this priority: reset -> RESET_PC; PCSrc_select_i=1 -> {branch_target_i[31:2],2'b00}; PCWrite_i=1 -> pc_o+4; otherwise hold.
REQ-018 PCSrc_select_i SHALL override PCWrite_i=0 in the same cycle (the redirect takes effect and the stall is discarded).
REQ-019 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no error flag.
REQ-020 IF/ID next-state priority: reset -> all zero; Flush_IFID_i=1 or PCSrc_select_i=1 -> instr=32'h0 (NOP), pc_plus4=32'h0, valid=0; WritePipeReg_IFID_i=1 -> instr=instr_i, pc_plus4=pc_o+4, valid=1; otherwise hold all three.
REQ-021 A flush SHALL override WritePipeReg_IFID_i=0 (a bubble is written even while stalled).
REQ-022 Latency SHALL be one cycle: instr_i sampled at edge N appears on instr_IFID_o after edge N.
REQ-023 A stall cycle SHALL be defined as WritePipeReg_IFID_i=0 and no flush and no PCSrc_select_i; stall_cnt_o SHALL increment by 1 per stall cycle.
REQ-024 A flush cycle SHALL be defined as Flush_IFID_i=1 or PCSrc_select_i=1; flush_cnt_o SHALL increment by 1 per flush cycle, counted once even if both are high.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and hold until reset.
REQ-026 PCWrite_i=0 with WritePipeReg_IFID_i=1 SHALL be legal: PC holds and IF/ID reloads the same instruction each cycle.
REQ-027 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-028 When rst_i=0 at a rising edge, the next state SHALL be: pc_o=RESET_PC, instr_IFID_o=0, pc_plus4_IFID_o=0, valid_IFID_o=0, stall_cnt_o=0, flush_cnt_o=0.
REQ-029 Reset SHALL override every other input, including a simultaneous redirect or flush.
REQ-030 Reset asserted mid-stall SHALL clear state in that cycle; the first edge with rst_i=1 SHALL fetch from RESET_PC.

Verification
REQ-031 Sequential fetch: release reset, PCWrite=WritePipeReg=1, instr_i=0x20080005 -> pc_o sequence 0,4,8; after edge 1: instr_IFID_o=0x20080005, pc_plus4_IFID_o=4, valid_IFID_o=1.
REQ-032 Load-use stall: at pc_o=8, PCWrite=WritePipeReg=0 for 1 cycle -> pc_o stays 8, IF/ID unchanged, stall_cnt_o=1; the next cycle resumes at pc_o=12.
REQ-033 Redirect during stall: PCWrite=0, WritePipeReg=0, PCSrc_select=1, branch_target=0x00000043 -> pc_o=0x40, instr_IFID_o=0, valid_IFID_o=0, flush_cnt_o+1, stall_cnt_o unchanged.
REQ-034 Flush with branch: Flush_IFID=1 and PCSrc_select=1 together -> flush_cnt_o increments by exactly 1.
REQ-035 Wrap and saturation: RESET_PC=0xFFFFFFFC, CNT_W=2 -> pc_o 0xFFFFFFFC then 0x0; 5 consecutive stall cycles -> stall_cnt_o=3 (saturated).
REQ-036 Mid-operation reset: after stall_cnt_o=2, apply rst_i=0 for 1 cycle -> all outputs 0, pc_o=RESET_PC.
